// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared constants and sizing helpers for the memory-port arbiter.
//   ARB_FIXED / ARB_RR : arbitration mode selectors.
//   clog2()            : ceiling log2, used to size port indices.
//   idx_w()            : port-index width, never below 1 so NUM_PORTS=1 still has a legal vector.
//   be_w()             : byte-enable width for a given data width.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bus of the arbiter.
//   req_*      : flattened per-port request fields (port i at [i*W +: W]).
//   req_ready  : one-hot grant.
//   resp_*     : one-hot response strobe plus shared read data.
//   mem_*      : pipelined cache-style memory port with global stall.
// slave  = the arbiter's view, master = the environment's view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int BE_W = be_w(DATA_W);

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*BE_W-1:0]   req_we;
    logic [NUM_PORTS*DATA_W-1:0] req_din;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        resp_valid;
    logic [DATA_W-1:0]           resp_dout;
    logic [ADDR_W-1:0]           mem_addr;
    logic [BE_W-1:0]             mem_we;
    logic                        mem_re;
    logic [DATA_W-1:0]           mem_din;
    logic [DATA_W-1:0]           mem_dout;
    logic                        mem_stall;

    modport slave (
        input  req_valid, req_addr, req_we, req_din, mem_dout, mem_stall,
        output req_ready, resp_valid, resp_dout, mem_addr, mem_we, mem_re, mem_din
    );

    modport master (
        output req_valid, req_addr, req_we, req_din, mem_dout, mem_stall,
        input  req_ready, resp_valid, resp_dout, mem_addr, mem_we, mem_re, mem_din
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester per enabled cycle.
//   clk, reset : clock, synchronous active-high reset.
//   req        : request vector.
//   advance    : grant enable (low while the memory stalls or in reset).
//   gnt        : one-hot grant, zero when advance is low.
//   gnt_idx    : binary index of the winner (valid whenever any req is set).
// Fixed mode: lowest index wins. Round-robin: search starts at the pointer and
// wraps; the pointer moves to winner+1 on every grant.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = ARB_RR,
    parameter int IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               cand;

    // Scan NUM_PORTS candidates starting at the pointer; first requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = ((ARB_MODE == ARB_RR) ? int'(ptr_q) : 0) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    found   = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            gnt[i] = advance && found && (gnt_idx == IDX_W'(i));
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE == ARB_RR) && advance && found)
            ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NUM_PORTS requesters onto one pipelined memory port.
//   clk, reset : clock, synchronous active-high reset.
//   bus        : mem_port_arbiter_if.slave (requests, grants, responses, memory).
// Pipeline: grant in cycle N -> issue register drives memory in N+1 ->
// response strobe in N+2. A memory stall freezes every register and
// suppresses grants and response strobes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = ARB_RR
) (
    input logic             clk,
    input logic             reset,
    mem_port_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_PORTS);
    localparam int BE_W  = be_w(DATA_W);

    logic                 advance;
    logic [NUM_PORTS-1:0] gnt;
    logic [IDX_W-1:0]     gnt_idx;

    logic                 issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]     issue_port_q,  issue_port_d;
    logic [ADDR_W-1:0]    addr_q,        addr_d;
    logic [BE_W-1:0]      we_q,          we_d;
    logic [DATA_W-1:0]    din_q,         din_d;
    logic                 resp_pending_q, resp_pending_d;
    logic [IDX_W-1:0]     resp_port_q,    resp_port_d;

    // Reset also blocks grants so no request is consumed while state is cleared.
    assign advance = !bus.mem_stall && !reset;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE),
        .IDX_W     (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (advance),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        issue_valid_d  = issue_valid_q;
        issue_port_d   = issue_port_q;
        addr_d         = addr_q;
        we_d           = we_q;
        din_d          = din_q;
        resp_pending_d = resp_pending_q;
        resp_port_d    = resp_port_q;
        if (advance) begin
            // Memory accepted whatever the issue stage held.
            resp_pending_d = issue_valid_q;
            resp_port_d    = issue_port_q;
            issue_valid_d  = |gnt;
            if (|gnt) issue_port_d = gnt_idx;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt[i]) begin
                    addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
                    we_d   = bus.req_we[i*BE_W +: BE_W];
                    din_d  = bus.req_din[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q  <= 1'b0;
            issue_port_q   <= '0;
            addr_q         <= '0;
            we_q           <= '0;
            din_q          <= '0;
            resp_pending_q <= 1'b0;
            resp_port_q    <= '0;
        end else begin
            issue_valid_q  <= issue_valid_d;
            issue_port_q   <= issue_port_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            din_q          <= din_d;
            resp_pending_q <= resp_pending_d;
            resp_port_q    <= resp_port_d;
        end
    end

    always_comb begin
        bus.req_ready  = gnt;
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            bus.resp_valid[i] = advance && resp_pending_q && (resp_port_q == IDX_W'(i));
        bus.resp_dout  = bus.mem_dout;
        bus.mem_re     = issue_valid_q && (we_q == '0);
        bus.mem_we     = issue_valid_q ? we_q : '0;
        bus.mem_addr   = addr_q;
        bus.mem_din    = din_q;
    end

endmodule
